// File: rtl/nn_pkg.sv
// Shared types and widths for the NN layer sequencer.
// Holds the FSM state encoding and datapath width constants.
package nn_pkg;

  localparam int ACC_W   = 32;
  localparam int DATA_W  = 8;
  localparam int SHIFT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    ACT,
    WRITE,
    FIN
  } nn_seq_state_t;

endpackage

// File: rtl/activation_module.sv
// Shift, saturate to int8 and optional ReLU of a 32-bit accumulator.
// Ports: acc_i (accumulator), shift_i, output_layer_i (1 = no ReLU), data_o.
module activation_module
  import nn_pkg::*;
(
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic               output_layer_i,
  output logic [DATA_W-1:0]  data_o
);

  logic signed [ACC_W-1:0] sh;

  assign sh = $signed(acc_i) >>> shift_i;

  always_comb begin
    data_o = sh[DATA_W-1:0];
    if (sh > 32'sd127) begin
      data_o = 8'h7f;
    end else if (sh < -32'sd128) begin
      data_o = 8'h80;
    end
    if (!output_layer_i && sh[ACC_W-1]) begin
      data_o = '0;
    end
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Runs one fully-connected layer on a shared MAC + activation path.
// Ports: config/start/busy/done, memory read port, valid/ready result port.
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int IN_AW  = 8,
  parameter int NEUR_W = 6,
  parameter int W_AW   = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [IN_AW-1:0]  cfg_num_inputs,
  input  logic [NEUR_W-1:0] cfg_num_neurons,
  input  logic [3:0]        cfg_shift,
  input  logic              cfg_output_layer,
  output logic              rd_en,
  output logic [IN_AW-1:0]  in_addr,
  output logic [W_AW-1:0]   w_addr,
  input  logic [7:0]        in_data,
  input  logic [7:0]        w_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [NEUR_W-1:0] res_addr,
  output logic [7:0]        res_data,
  output logic              busy,
  output logic              done
);

  nn_seq_state_t state_q, state_d;

  logic [IN_AW-1:0]   n_q, n_d, i_q, i_d;
  logic [NEUR_W-1:0]  m_q, m_d, neur_q, neur_d;
  logic [SHIFT_W-1:0] sh_q, sh_d;
  logic               outl_q, outl_d;
  logic [W_AW-1:0]    base_q, base_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               rdv_q;
  logic [DATA_W-1:0]  rdat_q, rdat_d, act;
  logic [NEUR_W-1:0]  radr_q, radr_d;
  logic signed [15:0] prod;

  assign prod = $signed(in_data) * $signed(w_data);

  activation_module u_act (
    .acc_i          (acc_q),
    .shift_i        (sh_q),
    .output_layer_i (outl_q),
    .data_o         (act)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    m_d     = m_q;
    sh_d    = sh_q;
    outl_d  = outl_q;
    i_d     = i_q;
    neur_d  = neur_q;
    base_d  = base_q;
    acc_d   = acc_q;
    rdat_d  = rdat_q;
    radr_d  = radr_q;
    // Data returns one cycle after each read strobe.
    if (rdv_q) begin
      acc_d = acc_q + {{(ACC_W-16){prod[15]}}, prod};
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d    = cfg_num_inputs;
          m_d    = cfg_num_neurons;
          sh_d   = cfg_shift;
          outl_d = cfg_output_layer;
          i_d    = '0;
          neur_d = '0;
          base_d = '0;
          acc_d  = '0;
          if (cfg_num_neurons == '0)
            state_d = FIN;
          else if (cfg_num_inputs == '0)
            state_d = DRAIN;
          else
            state_d = MAC;
        end
      end
      MAC: begin
        i_d = i_q + IN_AW'(1);
        if (i_q == n_q - IN_AW'(1)) begin
          i_d     = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: state_d = ACT;
      ACT: begin
        rdat_d  = act;
        radr_d  = neur_q;
        state_d = WRITE;
      end
      WRITE: begin
        if (res_ready) begin
          acc_d  = '0;
          base_d = base_q + W_AW'(n_q);
          neur_d = neur_q + NEUR_W'(1);
          if (neur_q == m_q - NEUR_W'(1))
            state_d = FIN;
          else if (n_q == '0)
            state_d = DRAIN;
          else
            state_d = MAC;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      m_q     <= '0;
      sh_q    <= '0;
      outl_q  <= 1'b0;
      i_q     <= '0;
      neur_q  <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      rdv_q   <= 1'b0;
      rdat_q  <= '0;
      radr_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      m_q     <= m_d;
      sh_q    <= sh_d;
      outl_q  <= outl_d;
      i_q     <= i_d;
      neur_q  <= neur_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      rdv_q   <= (state_q == MAC);
      rdat_q  <= rdat_d;
      radr_q  <= radr_d;
    end
  end

  assign rd_en     = (state_q == MAC);
  assign in_addr   = i_q;
  assign w_addr    = base_q + W_AW'(i_q);
  assign res_valid = (state_q == WRITE);
  assign res_data  = rdat_q;
  assign res_addr  = radr_q;
  assign done      = (state_q == FIN);
  assign busy      = (state_q == MAC) || (state_q == DRAIN) ||
                     (state_q == ACT) || (state_q == WRITE);

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Self-checking bench for nn_layer_sequencer with a layer-level model.
// Memories and a result/read monitor live here; expectations use plain math.
module tb_nn_layer_sequencer;

  logic       clk = 0;
  logic       reset_n = 0;
  logic       start = 0;
  logic [7:0] cfg_num_inputs = 0;
  logic [5:0] cfg_num_neurons = 0;
  logic [3:0] cfg_shift = 0;
  logic       cfg_output_layer = 0;
  logic       rd_en;
  logic [7:0] in_addr;
  logic [13:0] w_addr;
  logic [7:0] in_data = 0;
  logic [7:0] w_data = 0;
  logic       res_valid;
  logic       res_ready = 1;
  logic [5:0] res_addr;
  logic [7:0] res_data;
  logic       busy;
  logic       done;

  nn_layer_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_num_inputs(cfg_num_inputs), .cfg_num_neurons(cfg_num_neurons),
    .cfg_shift(cfg_shift), .cfg_output_layer(cfg_output_layer),
    .rd_en(rd_en), .in_addr(in_addr), .w_addr(w_addr),
    .in_data(in_data), .w_data(w_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] in_mem [256];
  logic [7:0] w_mem [16384];

  always @(posedge clk) begin
    if (rd_en) begin
      in_data <= in_mem[in_addr];
      w_data  <= w_mem[w_addr];
    end
  end

  int checks = 0;
  int fails = 0;
  bit rand_ready = 0;

  int cyc = 0, first_rd = -1, start_cyc = -1, done_c = -1, done_n = 0;
  int rd_in[$], rd_w[$], res_a[$], res_d[$], xfer_c[$];
  bit lv = 0, lr = 0;
  logic [7:0] ld;
  logic [5:0] la;

  always @(negedge clk) if (rand_ready) res_ready = 1'($urandom_range(0, 1));

  always @(posedge clk) begin
    if (!reset_n) begin
      lv = 0;
    end else begin
      cyc++;
      if (lv && !lr) begin
        checks++;
        if (res_valid !== 1'b1 || res_data !== ld || res_addr !== la || rd_en !== 1'b0) begin
          fails++;
          $display("FAIL hold: valid=%b data=%h addr=%0d rd_en=%b required valid=1 data=%h addr=%0d rd_en=0",
                   res_valid, res_data, res_addr, rd_en, ld, la);
        end
      end
      if (rd_en) begin
        rd_in.push_back(int'(in_addr));
        rd_w.push_back(int'(w_addr));
        if (first_rd < 0) first_rd = cyc;
      end
      if (start && start_cyc < 0) start_cyc = cyc;
      if (res_valid && res_ready) begin
        res_a.push_back(int'(res_addr));
        res_d.push_back(int'($signed(res_data)));
        xfer_c.push_back(cyc);
      end
      if (done) begin
        done_n++;
        done_c = cyc;
      end
      lv = res_valid; lr = res_ready; ld = res_data; la = res_addr;
    end
  end

  function automatic int act_ref(int acc, int sh, bit outl);
    int s;
    s = acc >>> sh;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    if (!outl && s < 0) s = 0;
    return s;
  endfunction

  function automatic int neuron_ref(int n, int nn, int sh, bit outl);
    int acc = 0;
    for (int i = 0; i < nn; i++)
      acc += int'($signed(in_mem[i])) * int'($signed(w_mem[(n * nn + i) % 16384]));
    return act_ref(acc, sh, outl);
  endfunction

  task automatic clear_mon();
    rd_in.delete(); rd_w.delete(); res_a.delete(); res_d.delete(); xfer_c.delete();
    first_rd = -1; start_cyc = -1; done_c = -1; done_n = 0;
  endtask

  task automatic run_layer(input int nn, input int m, input int sh, input bit outl,
                           input bit rnd, input bit poke);
    int bad;
    clear_mon();
    @(negedge clk);
    rand_ready = rnd;
    if (!rnd) res_ready = 1;
    cfg_num_inputs = 8'(nn); cfg_num_neurons = 6'(m);
    cfg_shift = 4'(sh); cfg_output_layer = outl;
    start = 1;
    @(negedge clk);
    start = 0;
    cfg_num_inputs = 8'($urandom); cfg_num_neurons = 6'($urandom);
    cfg_shift = 4'($urandom); cfg_output_layer = 1'($urandom);
    if (poke) begin
      repeat (2) @(negedge clk);
      if (busy) begin
        start = 1;
        @(negedge clk);
        start = 0;
      end
    end
    for (int k = 0; k < 20000 && done_n == 0; k++) @(negedge clk);
    checks++;
    if (done_n == 0) begin
      fails++;
      $display("FAIL timeout: done not seen, N=%0d M=%0d", nn, m);
    end
    repeat (3) @(negedge clk);
    rand_ready = 0;
    res_ready = 1;
    checks++;
    if (done_n !== 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse: count=%0d busy=%b required count=1 busy=0", done_n, busy);
    end
    checks++;
    if (res_d.size() != m) begin
      fails++;
      $display("FAIL result_count: got %0d required %0d", res_d.size(), m);
    end
    for (int n = 0; n < m && n < res_d.size(); n++) begin
      checks++;
      if (res_a[n] != n || res_d[n] != neuron_ref(n, nn, sh, outl)) begin
        fails++;
        $display("FAIL result[%0d]: addr=%0d data=%0d required addr=%0d data=%0d",
                 n, res_a[n], res_d[n], n, neuron_ref(n, nn, sh, outl));
      end
    end
    bad = -1;
    if (rd_in.size() != m * nn) bad = rd_in.size();
    else
      for (int k = 0; k < m * nn; k++)
        if (bad < 0 && (rd_in[k] != k % nn || rd_w[k] != k % 16384)) bad = k;
    checks++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL reads: %0d reads, first bad at %0d, required %0d sequential reads",
               rd_in.size(), bad, m * nn);
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rd_en, res_valid, busy, done} !== 4'b0 || in_addr !== 0 || w_addr !== 0 ||
        res_addr !== 0 || res_data !== 0) begin
      fails++;
      $display("FAIL reset_outputs: rd=%b v=%b busy=%b done=%b ia=%0d wa=%0d ra=%0d rd=%0d required all 0",
               rd_en, res_valid, busy, done, in_addr, w_addr, res_addr, res_data);
    end
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single();
    for (int i = 0; i < 4; i++) begin in_mem[i] = 8'd1; w_mem[i] = 8'd2; end
    run_layer(4, 1, 0, 0, 0, 0);
    checks++;
    if (res_d.size() != 1 || res_d[0] != 8 || res_a[0] != 0) begin
      fails++;
      $display("FAIL single: results=%0d required one result 8 at addr 0", res_d.size());
    end
    checks++;
    if (xfer_c.size() != 1 || xfer_c[0] - first_rd != 6 || done_c != xfer_c[0] + 1) begin
      fails++;
      $display("FAIL latency: first_rd=%0d done=%0d required transfer at first_rd+6, done 1 later",
               first_rd, done_c);
    end
  endtask

  task automatic test_relu_sat();
    for (int i = 0; i < 3; i++) in_mem[i] = 8'd10;
    w_mem[0] = -8'sd1; w_mem[1] = -8'sd2; w_mem[2] = -8'sd1;
    for (int i = 3; i < 6; i++) w_mem[i] = 8'd20;
    run_layer(3, 2, 2, 0, 0, 0);
    checks++;
    if (res_d.size() != 2 || res_d[0] != 0 || res_d[1] != 127) begin
      fails++;
      $display("FAIL relu_sat: got %0d results required 0 then 127", res_d.size());
    end
  endtask

  task automatic test_output_layer();
    for (int i = 0; i < 2; i++) begin in_mem[i] = 8'h80; w_mem[i] = 8'd127; end
    run_layer(2, 1, 0, 1, 0, 0);
    checks++;
    if (res_d.size() != 1 || res_d[0] != -128) begin
      fails++;
      $display("FAIL out_layer_sh0: got %0d results required -128", res_d.size());
    end
    run_layer(2, 1, 8, 1, 0, 0);
    checks++;
    if (res_d.size() != 1 || res_d[0] != -127) begin
      fails++;
      $display("FAIL out_layer_sh8: got %0d results required -127", res_d.size());
    end
  endtask

  task automatic test_backpressure();
    int k;
    logic [7:0] d0;
    in_mem[0] = 8'd3; in_mem[1] = 8'd4; w_mem[0] = 8'd5; w_mem[1] = -8'sd6;
    clear_mon();
    @(negedge clk);
    res_ready = 0;
    cfg_num_inputs = 2; cfg_num_neurons = 1; cfg_shift = 0; cfg_output_layer = 1;
    start = 1;
    @(negedge clk);
    start = 0;
    for (k = 0; k < 50 && !res_valid; k++) @(negedge clk);
    d0 = res_data;
    checks++;
    if (res_valid !== 1'b1 || d0 !== 8'hf7 || res_addr !== 0) begin
      fails++;
      $display("FAIL bp_first: valid=%b data=%h addr=%0d required valid=1 data=f7 addr=0",
               res_valid, d0, res_addr);
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== d0 || rd_en !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold: valid=%b data=%h rd_en=%b required 1/%h/0",
                 res_valid, res_data, rd_en, d0);
      end
    end
    res_ready = 1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || done !== 1'b1 || res_d.size() != 1) begin
      fails++;
      $display("FAIL bp_xfer: valid=%b done=%b results=%0d required 0/1/1",
               res_valid, done, res_d.size());
    end
    @(negedge clk);
  endtask

  task automatic test_zero();
    run_layer(0, 3, 0, 0, 0, 0);
    checks++;
    if (res_d.size() != 3 || res_d[0] != 0 || res_d[2] != 0 || rd_in.size() != 0) begin
      fails++;
      $display("FAIL n_zero: results=%0d reads=%0d required 3 zeros and no reads",
               res_d.size(), rd_in.size());
    end
    run_layer(5, 0, 0, 0, 0, 0);
    checks++;
    if (done_c - start_cyc != 1 || res_d.size() != 0) begin
      fails++;
      $display("FAIL m_zero: done %0d cycles after start, results=%0d required 1 and 0",
               done_c - start_cyc, res_d.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) in_mem[i] = 8'($urandom);
    for (int i = 0; i < 16384; i++) w_mem[i] = 8'($urandom);
    for (int t = 0; t < 10; t++)
      run_layer($urandom_range(0, 12), $urandom_range(0, 6), $urandom_range(0, 15),
                1'($urandom), 1'($urandom), 1'b1);
  endtask

  task automatic test_reset_mid();
    int k;
    clear_mon();
    @(negedge clk);
    res_ready = 1;
    cfg_num_inputs = 5; cfg_num_neurons = 3; cfg_shift = 1; cfg_output_layer = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    for (k = 0; k < 100 && !(rd_en && w_addr >= 6); k++) @(negedge clk);
    reset_n = 0;
    #1;
    checks++;
    if ({rd_en, res_valid, busy, done} !== 4'b0 || in_addr !== 0 || w_addr !== 0 ||
        res_data !== 0 || res_addr !== 0) begin
      fails++;
      $display("FAIL reset_mid: rd=%b v=%b busy=%b done=%b ia=%0d wa=%0d required all 0",
               rd_en, res_valid, busy, done, in_addr, w_addr);
    end
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (done_n != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_abandon: done_count=%0d busy=%b required 0/0", done_n, busy);
    end
    run_layer(5, 3, 1, 0, 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) in_mem[i] = 0;
    for (int i = 0; i < 16384; i++) w_mem[i] = 0;
    test_reset();
    test_single();
    test_relu_sat();
    test_output_layer();
    test_backpressure();
    test_zero();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
